// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction RAM loader.
package loader_pkg;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
        CHK,
        FIN,
        ERR
    } loader_state_t;

    localparam int unsigned LEN_BYTES  = 2;
    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/byte_word_packer.sv
// Assembles big-endian 32-bit words from a byte stream; pulses word_valid after the 4th byte.
module byte_word_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        last_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  phase_q;
    logic [31:0] shift_q;
    logic        word_valid_q;

    assign last_byte  = byte_valid && (phase_q == 2'(WORD_BYTES - 1));
    assign word_valid = word_valid_q;
    assign word       = shift_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q      <= '0;
            shift_q      <= '0;
            word_valid_q <= 1'b0;
        end else if (clear) begin
            phase_q      <= '0;
            shift_q      <= '0;
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= last_byte;
            if (byte_valid) begin
                shift_q <= {shift_q[23:0], byte_data};
                phase_q <= phase_q + 2'd1;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader for instruction RAM; holds the CPU in reset until the image is written.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned AW        = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_req,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          cpu_reset,
    output logic          done,
    output logic          error,
    output logic [15:0]   words_loaded
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_t AFTER_DATA = CHK;
`else
    localparam loader_state_t AFTER_DATA = FIN;
`endif

    loader_state_t          state_q;
    logic [LEN_BYTES*8-1:0] len_q;
    logic [15:0]            len_now;
    logic                   xfer, last_byte, word_valid, last_word, released;
    logic [31:0]            word;

    assign in_ready  = state_q inside {LEN_HI, LEN_LO, DATA, CHK};
    assign xfer      = in_valid && in_ready && !load_req;
    assign len_now   = {len_q[15:8], in_data};
    // Writes trail byte acceptance by one cycle, so words_loaded is exact by the 4th byte.
    assign last_word = words_loaded == (len_q - 16'd1);
    // Release only once the final write has left the packer.
    assign released  = (state_q == FIN) && !word_valid;

    byte_word_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (load_req),
        .byte_valid(xfer && (state_q == DATA)),
        .byte_data (in_data),
        .last_byte (last_byte),
        .word_valid(word_valid),
        .word      (word)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] cksum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cksum_q <= '0;
        end else if (load_req) begin
            cksum_q <= '0;
        end else if (xfer && (state_q == DATA)) begin
            cksum_q <= cksum_q ^ in_data;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= LEN_HI;
            len_q        <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_reset    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else if (load_req) begin
            state_q      <= LEN_HI;
            len_q        <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            cpu_reset    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            mem_we    <= word_valid;
            done      <= released;
            cpu_reset <= !released;
            error     <= state_q == ERR;
            if (word_valid) begin
                mem_addr     <= words_loaded[AW-1:0];
                mem_wdata    <= word;
                words_loaded <= words_loaded + 16'd1;
            end
            if (xfer) begin
                unique case (state_q)
                    LEN_HI: begin
                        len_q[15:8] <= in_data;
                        state_q     <= LEN_LO;
                    end
                    LEN_LO: begin
                        len_q <= len_now;
                        if (32'(len_now) > MEM_DEPTH) begin
                            state_q <= ERR;
                        end else if (len_now == 16'd0) begin
                            state_q <= AFTER_DATA;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                    DATA: begin
                        if (last_byte && last_word) begin
                            state_q <= AFTER_DATA;
                        end
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    CHK: state_q <= (in_data == cksum_q) ? FIN : ERR;
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader; expected RAM writes are queued, a negedge monitor checks them.
module tb_imem_loader;

    localparam int unsigned MEM_DEPTH = 256;
    localparam int unsigned AW        = 8;

    typedef logic [7:0] bq_t[$];

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_req = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready, mem_we, cpu_reset, done, error;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [15:0]   words_loaded;

    int checks = 0;
    int errors = 0;
    logic [AW+31:0] exp_q[$];
    logic prev_we = 1'b0;

    imem_loader #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_req    (load_req),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .cpu_reset   (cpu_reset),
        .done        (done),
        .error       (error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected-write queue.
    always @(negedge clk) begin
        logic [AW+31:0] e;
        if (!reset && mem_we) begin
            check("we_single_cycle", 32'(prev_we), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                         mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 32'(mem_addr), 32'(e[AW+31:32]));
                check("write_data", mem_wdata, e[31:0]);
            end
        end
        prev_we = mem_we;
    end

    task automatic expect_write(input logic [AW-1:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_stream(input bq_t s, input int maxgap);
        foreach (s[i]) send_byte(s[i], int'($urandom_range(0, maxgap)));
    endtask

    task automatic pulse_load_req();
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bq_t s;

        // Reset values
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        reset = 1'b0;

        // Two-word image, back-to-back bytes
        s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h0A, 8'h20, 8'h09, 8'h00, 8'h14};
`ifdef IMEM_LOADER_CHECKSUM_EN
        s.push_back(8'h1F);
`endif
        expect_write(8'd0, 32'h2008000A);
        expect_write(8'd1, 32'h20090014);
        send_stream(s, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("t1_done_early", 32'(done), 32'd0);
        @(posedge clk);
        #1;
`else
        check("t1_done_t", 32'(done), 32'd0);
        check("t1_ready_fin", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("t1_we_t1", 32'(mem_we), 32'd1);
        check("t1_done_t1", 32'(done), 32'd0);
        check("t1_cpurst_t1", 32'(cpu_reset), 32'd1);
        @(posedge clk);
        #1;
`endif
        check("t1_done", 32'(done), 32'd1);
        check("t1_cpu_reset", 32'(cpu_reset), 32'd0);
        check("t1_words", 32'(words_loaded), 32'd2);
        check("t1_error", 32'(error), 32'd0);
        check("t1_ready", 32'(in_ready), 32'd0);

        // Same image with random in_valid gaps
        do_reset();
        expect_write(8'd0, 32'h2008000A);
        expect_write(8'd1, 32'h20090014);
        send_stream(s, 3);
        repeat (3) @(posedge clk);
        #1;
        check("t2_done", 32'(done), 32'd1);
        check("t2_cpu_reset", 32'(cpu_reset), 32'd0);
        check("t2_words", 32'(words_loaded), 32'd2);
        check("t2_error", 32'(error), 32'd0);

        // Length 257 exceeds depth
        do_reset();
        s = '{8'h01, 8'h01};
        send_stream(s, 0);
        check("t3_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("t3_error", 32'(error), 32'd1);
        check("t3_cpu_reset", 32'(cpu_reset), 32'd1);
        check("t3_done", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t3_words", 32'(words_loaded), 32'd0);
        check("t3_error_sticky", 32'(error), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum good, then bad
        pulse_load_req();
        expect_write(8'd0, 32'h11223344);
        s = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        send_stream(s, 0);
        @(posedge clk);
        #1;
        check("ck_good_done", 32'(done), 32'd1);
        check("ck_good_error", 32'(error), 32'd0);
        pulse_load_req();
        expect_write(8'd0, 32'h11223344);
        s = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        send_stream(s, 0);
        @(posedge clk);
        #1;
        check("ck_bad_error", 32'(error), 32'd1);
        check("ck_bad_done", 32'(done), 32'd0);
        check("ck_bad_cpu_reset", 32'(cpu_reset), 32'd1);
`endif

        // load_req from ERR, partial image, load_req with a colliding byte, fresh image
        pulse_load_req();
        check("lr_ready", 32'(in_ready), 32'd1);
        check("lr_error", 32'(error), 32'd0);
        check("lr_cpu_reset", 32'(cpu_reset), 32'd1);
        expect_write(8'd0, 32'h01020304);
        s = '{8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_stream(s, 0);
        in_valid = 1'b1;
        in_data  = 8'h77;
        pulse_load_req();
        check("lr2_words", 32'(words_loaded), 32'd0);
        check("lr2_ready", 32'(in_ready), 32'd1);
        check("lr2_cpu_reset", 32'(cpu_reset), 32'd1);
        expect_write(8'd0, 32'hDEADBEEF);
        s = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef IMEM_LOADER_CHECKSUM_EN
        s.push_back(8'h22);
`endif
        send_stream(s, 0);
        repeat (2) @(posedge clk);
        #1;
        check("lr3_done", 32'(done), 32'd1);
        check("lr3_words", 32'(words_loaded), 32'd1);
        check("lr3_addr", 32'(mem_addr), 32'd0);

        // Asynchronous reset mid-DATA, then a clean reload
        pulse_load_req();
        expect_write(8'd0, 32'hAABBCCDD);
        s = '{8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11};
        send_stream(s, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("ar_mem_we", 32'(mem_we), 32'd0);
        check("ar_mem_addr", 32'(mem_addr), 32'd0);
        check("ar_mem_wdata", mem_wdata, 32'd0);
        check("ar_words", 32'(words_loaded), 32'd0);
        check("ar_cpu_reset", 32'(cpu_reset), 32'd1);
        check("ar_done", 32'(done), 32'd0);
        check("ar_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        expect_write(8'd0, 32'hCAFEBABE);
        s = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
`ifdef IMEM_LOADER_CHECKSUM_EN
        s.push_back(8'h30);
`endif
        send_stream(s, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rl_done", 32'(done), 32'd1);
        check("rl_words", 32'(words_loaded), 32'd1);
        check("rl_cpu_reset", 32'(cpu_reset), 32'd0);

        repeat (2) @(posedge clk);
        #1;
        check("writes_pending", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
